apb_width_downconverter: RTL and testbench

- Parametrised successor to the fixed 64-to-32 APB write buffer in the FMC bridge path: converts one wide upstream APB completer port into a narrow downstream APB requester port for any power-of-two width ratio.
- Sits between a wide FMC APB segment and a narrow peripheral bridge or register slice.
- Adds behaviour the fixed 64-to-32 buffer lacks:
  - skips write beats whose strobes are all zero;
  - optionally posts writes, with a sticky error flag;
  - reports a busy status.

---
 rtl/apb_width_downconverter.sv | 240 ++++++++++++++++++++++++
 tb/tb_apb_width_downconverter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_width_downconverter.sv
// Wide-to-narrow APB bridge: each upstream transfer becomes up to RATIO
// downstream beats (LSB lane first). Writes may be posted; all-zero-strobe beats are skipped.
module apb_width_downconverter #(
  parameter int UP_WIDTH    = 64,
  parameter int DOWN_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 20,
  parameter int POST_WRITES = 1
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    up_psel,
  input  logic                    up_penable,
  input  logic                    up_pwrite,
  input  logic [ADDR_WIDTH-1:0]   up_paddr,
  input  logic [UP_WIDTH-1:0]     up_pwdata,
  input  logic [UP_WIDTH/8-1:0]   up_pstrb,
  output logic [UP_WIDTH-1:0]     up_prdata,
  output logic                    up_pready,
  output logic                    up_pslverr,
  output logic                    down_psel,
  output logic                    down_penable,
  output logic                    down_pwrite,
  output logic [ADDR_WIDTH-1:0]   down_paddr,
  output logic [DOWN_WIDTH-1:0]   down_pwdata,
  output logic [DOWN_WIDTH/8-1:0] down_pstrb,
  input  logic [DOWN_WIDTH-1:0]   down_prdata,
  input  logic                    down_pready,
  input  logic                    down_pslverr,
  output logic                    posted_err,
  input  logic                    posted_err_clr,
  output logic                    busy
);

  localparam int RATIO   = UP_WIDTH / DOWN_WIDTH;
  localparam int BEAT_W  = $clog2(RATIO);
  localparam int UP_STRB = UP_WIDTH / 8;
  localparam int DN_STRB = DOWN_WIDTH / 8;
  localparam int UP_LSB  = $clog2(UP_STRB);
  localparam int DN_LSB  = $clog2(DN_STRB);
  localparam int BASE_W  = ADDR_WIDTH - UP_LSB;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                pwrite_q;
  logic                posted_q;
  logic                err_q;
  logic [BASE_W-1:0]   base_q;
  logic [UP_STRB-1:0]  strb_q;
  logic [UP_WIDTH-1:0] wdata_q;
  logic [UP_WIDTH-1:0] rdata_q;
  logic [UP_WIDTH-1:0] rdata_d;

  logic [UP_WIDTH-1:0]   up_prdata_q;
  logic                  up_pready_q;
  logic                  up_pslverr_q;
  logic                  down_psel_q;
  logic                  down_penable_q;
  logic                  down_pwrite_q;
  logic [ADDR_WIDTH-1:0] down_paddr_q;
  logic [DOWN_WIDTH-1:0] down_pwdata_q;
  logic [DN_STRB-1:0]    down_pstrb_q;
  logic                  posted_err_q;

  logic [BEAT_W:0] first_d;
  logic [BEAT_W:0] next_d;
  logic            accept;
  logic            beat_done;
  logic            posted_set;
  logic            unused_addr_lsb;

  // Lowest beat index >= from that needs a downstream cycle; MSB flags "found".
  function automatic logic [BEAT_W:0] seek_beat(input logic [UP_STRB-1:0] strb,
                                                 input logic is_wr, input int from);
    logic [BEAT_W:0] res;
    res = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i >= from && (!is_wr || strb[i*DN_STRB +: DN_STRB] != '0)) begin
        res = {1'b1, BEAT_W'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [BASE_W-1:0] base,
                                                      input logic [BEAT_W-1:0] idx);
    return {base, {UP_LSB{1'b0}}} | (ADDR_WIDTH'(idx) << DN_LSB);
  endfunction

  function automatic logic [DOWN_WIDTH-1:0] data_lane(input logic [UP_WIDTH-1:0] data,
                                                      input logic [BEAT_W-1:0] idx);
    return data[idx*DOWN_WIDTH +: DOWN_WIDTH];
  endfunction

  function automatic logic [DN_STRB-1:0] strb_lane(input logic [UP_STRB-1:0] strb,
                                                   input logic [BEAT_W-1:0] idx);
    return strb[idx*DN_STRB +: DN_STRB];
  endfunction

  assign accept     = (state_q == IDLE) && up_psel && up_penable;
  assign beat_done  = (state_q == ACCESS) && down_pready;
  assign posted_set = beat_done && down_pslverr && posted_q;
  assign first_d    = seek_beat(up_pstrb, up_pwrite, 0);
  assign next_d     = seek_beat(strb_q, pwrite_q, int'(beat_q) + 1);
  assign unused_addr_lsb = ^up_paddr[UP_LSB-1:0];

  always_comb begin
    rdata_d = rdata_q;
    rdata_d[beat_q*DOWN_WIDTH +: DOWN_WIDTH] = down_prdata;
  end

  // Payload registers; every read lane is rewritten before RESP, so no reset needed.
  always_ff @(posedge pclk) begin
    if (accept) begin
      wdata_q <= up_pwdata;
    end
    if (beat_done && !pwrite_q) begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      pwrite_q       <= 1'b0;
      posted_q       <= 1'b0;
      err_q          <= 1'b0;
      base_q         <= '0;
      strb_q         <= '0;
      up_prdata_q    <= '0;
      up_pready_q    <= 1'b0;
      up_pslverr_q   <= 1'b0;
      down_psel_q    <= 1'b0;
      down_penable_q <= 1'b0;
      down_pwrite_q  <= 1'b0;
      down_paddr_q   <= '0;
      down_pwdata_q  <= '0;
      down_pstrb_q   <= '0;
      posted_err_q   <= 1'b0;
    end else begin
      up_pready_q  <= 1'b0;
      up_pslverr_q <= 1'b0;
      up_prdata_q  <= '0;

      // A set in the same cycle as a clear must win.
      if (posted_set) begin
        posted_err_q <= 1'b1;
      end else if (posted_err_clr) begin
        posted_err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            pwrite_q <= up_pwrite;
            posted_q <= (POST_WRITES != 0) && up_pwrite;
            err_q    <= 1'b0;
            base_q   <= up_paddr[ADDR_WIDTH-1:UP_LSB];
            strb_q   <= up_pstrb;
            if (first_d[BEAT_W]) begin
              state_q        <= SETUP;
              beat_q         <= first_d[BEAT_W-1:0];
              down_psel_q    <= 1'b1;
              down_penable_q <= 1'b0;
              down_pwrite_q  <= up_pwrite;
              down_paddr_q   <= beat_addr(up_paddr[ADDR_WIDTH-1:UP_LSB], first_d[BEAT_W-1:0]);
              down_pwdata_q  <= up_pwrite ? data_lane(up_pwdata, first_d[BEAT_W-1:0]) : '0;
              down_pstrb_q   <= up_pwrite ? strb_lane(up_pstrb, first_d[BEAT_W-1:0]) : '0;
              up_pready_q    <= (POST_WRITES != 0) && up_pwrite;
            end else begin
              // Write with no strobes at all: nothing to send downstream.
              state_q     <= RESP;
              up_pready_q <= 1'b1;
            end
          end
        end

        SETUP: begin
          state_q        <= ACCESS;
          down_penable_q <= 1'b1;
        end

        ACCESS: begin
          if (down_pready) begin
            err_q <= err_q | down_pslverr;
            if (next_d[BEAT_W]) begin
              state_q        <= SETUP;
              beat_q         <= next_d[BEAT_W-1:0];
              down_penable_q <= 1'b0;
              down_paddr_q   <= beat_addr(base_q, next_d[BEAT_W-1:0]);
              down_pwdata_q  <= pwrite_q ? data_lane(wdata_q, next_d[BEAT_W-1:0]) : '0;
              down_pstrb_q   <= pwrite_q ? strb_lane(strb_q, next_d[BEAT_W-1:0]) : '0;
            end else begin
              down_psel_q    <= 1'b0;
              down_penable_q <= 1'b0;
              down_pwrite_q  <= 1'b0;
              down_paddr_q   <= '0;
              down_pwdata_q  <= '0;
              down_pstrb_q   <= '0;
              if (posted_q) begin
                // Upstream already completed; the drain simply ends.
                state_q <= IDLE;
              end else begin
                state_q      <= RESP;
                up_pready_q  <= 1'b1;
                up_pslverr_q <= err_q | down_pslverr;
                if (!pwrite_q) begin
                  up_prdata_q <= rdata_d;
                end
              end
            end
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign up_prdata    = up_prdata_q;
  assign up_pready    = up_pready_q;
  assign up_pslverr   = up_pslverr_q;
  assign down_psel    = down_psel_q;
  assign down_penable = down_penable_q;
  assign down_pwrite  = down_pwrite_q;
  assign down_paddr   = down_paddr_q;
  assign down_pwdata  = down_pwdata_q;
  assign down_pstrb   = down_pstrb_q;
  assign posted_err   = posted_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_apb_width_downconverter.sv
// Directed bench: three bridge instances (64/32 posted, 64/32 non-posted,
// 128/32 non-posted) sharing one scripted downstream responder.
module tb_apb_width_downconverter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [19:0] paddr;
  logic [127:0] pwdata;
  logic [15:0] pstrb;
  logic [31:0] dn_prdata;
  logic        dn_pready;
  logic        dn_pslverr;
  logic        err_clr;

  logic [63:0]  a_prdata, b_prdata;
  logic [127:0] c_prdata;
  logic        o_pready [3];
  logic        o_pslverr [3];
  logic        o_psel [3];
  logic        o_penable [3];
  logic        o_pwrite [3];
  logic        o_perr [3];
  logic        o_busy [3];
  logic [19:0] o_paddr [3];
  logic [31:0] o_pwdata [3];
  logic [3:0]  o_pstrb [3];

  int which = 0;
  int checks = 0;
  int errors = 0;

  logic [127:0] m_prdata;
  logic        m_pready, m_pslverr, m_psel, m_penable, m_perr, m_busy;
  logic [19:0] m_paddr;

  assign m_prdata  = (which == 2) ? c_prdata : (which == 1) ? {64'h0, b_prdata} : {64'h0, a_prdata};
  assign m_pready  = o_pready[which];
  assign m_pslverr = o_pslverr[which];
  assign m_psel    = o_psel[which];
  assign m_penable = o_penable[which];
  assign m_perr    = o_perr[which];
  assign m_busy    = o_busy[which];
  assign m_paddr   = o_paddr[which];

  always #5 clk = ~clk;

  apb_width_downconverter #(.UP_WIDTH(64), .DOWN_WIDTH(32), .ADDR_WIDTH(20), .POST_WRITES(1)) u_a (
    .pclk(clk), .preset_n(rst_n), .up_psel(psel[0]), .up_penable(penable), .up_pwrite(pwrite),
    .up_paddr(paddr), .up_pwdata(pwdata[63:0]), .up_pstrb(pstrb[7:0]), .up_prdata(a_prdata),
    .up_pready(o_pready[0]), .up_pslverr(o_pslverr[0]), .down_psel(o_psel[0]),
    .down_penable(o_penable[0]), .down_pwrite(o_pwrite[0]), .down_paddr(o_paddr[0]),
    .down_pwdata(o_pwdata[0]), .down_pstrb(o_pstrb[0]), .down_prdata(dn_prdata),
    .down_pready(dn_pready), .down_pslverr(dn_pslverr), .posted_err(o_perr[0]),
    .posted_err_clr(err_clr), .busy(o_busy[0]));

  apb_width_downconverter #(.UP_WIDTH(64), .DOWN_WIDTH(32), .ADDR_WIDTH(20), .POST_WRITES(0)) u_b (
    .pclk(clk), .preset_n(rst_n), .up_psel(psel[1]), .up_penable(penable), .up_pwrite(pwrite),
    .up_paddr(paddr), .up_pwdata(pwdata[63:0]), .up_pstrb(pstrb[7:0]), .up_prdata(b_prdata),
    .up_pready(o_pready[1]), .up_pslverr(o_pslverr[1]), .down_psel(o_psel[1]),
    .down_penable(o_penable[1]), .down_pwrite(o_pwrite[1]), .down_paddr(o_paddr[1]),
    .down_pwdata(o_pwdata[1]), .down_pstrb(o_pstrb[1]), .down_prdata(dn_prdata),
    .down_pready(dn_pready), .down_pslverr(dn_pslverr), .posted_err(o_perr[1]),
    .posted_err_clr(err_clr), .busy(o_busy[1]));

  apb_width_downconverter #(.UP_WIDTH(128), .DOWN_WIDTH(32), .ADDR_WIDTH(20), .POST_WRITES(0)) u_c (
    .pclk(clk), .preset_n(rst_n), .up_psel(psel[2]), .up_penable(penable), .up_pwrite(pwrite),
    .up_paddr(paddr), .up_pwdata(pwdata), .up_pstrb(pstrb), .up_prdata(c_prdata),
    .up_pready(o_pready[2]), .up_pslverr(o_pslverr[2]), .down_psel(o_psel[2]),
    .down_penable(o_penable[2]), .down_pwrite(o_pwrite[2]), .down_paddr(o_paddr[2]),
    .down_pwdata(o_pwdata[2]), .down_pstrb(o_pstrb[2]), .down_prdata(dn_prdata),
    .down_pready(dn_pready), .down_pslverr(dn_pslverr), .posted_err(o_perr[2]),
    .posted_err_clr(err_clr), .busy(o_busy[2]));

  // Scripted downstream completer: per-beat wait states, data and error, plus a beat log.
  int          bidx = 0;
  int          wcnt = 0;
  logic        rsp_clr = 1'b0;
  logic [31:0] rsp_data [8];
  int          rsp_wait [8];
  logic        rsp_err [8];
  logic [19:0] log_addr [8];
  logic [31:0] log_data [8];
  logic [3:0]  log_strb [8];
  logic        log_wr [8];

  always @(negedge clk) begin
    dn_pready  = 1'b0;
    dn_pslverr = 1'b0;
    dn_prdata  = '0;
    if (rsp_clr) begin
      bidx = 0;
      wcnt = 0;
    end else if (m_psel && m_penable && bidx < 8) begin
      if (wcnt < rsp_wait[bidx]) begin
        wcnt++;
      end else begin
        dn_pready      = 1'b1;
        dn_prdata      = rsp_data[bidx];
        dn_pslverr     = rsp_err[bidx];
        log_addr[bidx] = m_paddr;
        log_data[bidx] = o_pwdata[which];
        log_strb[bidx] = o_pstrb[which];
        log_wr[bidx]   = o_pwrite[which];
        bidx++;
        wcnt = 0;
      end
    end
  end

  task automatic rsp_clear();
    for (int i = 0; i < 8; i++) begin
      rsp_data[i] = '0;
      rsp_wait[i] = 0;
      rsp_err[i]  = 1'b0;
    end
    rsp_clr = 1'b1;
    @(negedge clk);
    #1 rsp_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input int w, input logic wr, input logic [19:0] addr,
                          input logic [127:0] wd, input logic [15:0] st,
                          output logic [127:0] rd, output logic er, output int n);
    which = w;
    @(posedge clk);
    #1;
    psel[w] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk);
    #1;
    penable = 1'b1;
    n = 0;
    rd = '0;
    er = 1'b0;
    forever begin
      @(negedge clk);
      if (m_pready) begin
        rd = m_prdata;
        er = m_pslverr;
        break;
      end
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL xfer_timeout inst %0d addr %h: no up_pready within 60 cycles", w, addr);
        break;
      end
    end
    @(posedge clk);
    #1;
    psel[w] = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    which = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_psel !== 1'b0) begin errors++; $display("FAIL rst_psel got %b exp 0", m_psel); end
    checks++; if (m_penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", m_penable); end
    checks++; if (m_pready !== 1'b0) begin errors++; $display("FAIL rst_pready got %b exp 0", m_pready); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", m_busy); end
    checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL rst_posted_err got %b exp 0", m_perr); end
    checks++; if (m_paddr !== 20'h0) begin errors++; $display("FAIL rst_paddr got %h exp 0", m_paddr); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read64();
    logic [127:0] rd; logic er; int n;
    rsp_clear();
    rsp_data[0] = 32'h11111111; rsp_data[1] = 32'h22222222;
    apb_xfer(0, 1'b0, 20'h00100, '0, '0, rd, er, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rd64_latency got %0d exp 5", n); end
    checks++; if (rd !== 128'h22222222_11111111) begin errors++; $display("FAIL rd64_data got %h exp 2222222211111111", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd64_slverr got %b exp 0", er); end
    checks++; if (log_addr[0] !== 20'h00100) begin errors++; $display("FAIL rd64_addr0 got %h exp 00100", log_addr[0]); end
    checks++; if (log_addr[1] !== 20'h00104) begin errors++; $display("FAIL rd64_addr1 got %h exp 00104", log_addr[1]); end
    checks++; if (log_strb[1] !== 4'h0) begin errors++; $display("FAIL rd64_strb got %h exp 0", log_strb[1]); end
    @(negedge clk);
    checks++; if (m_prdata !== 128'h0) begin errors++; $display("FAIL rd64_prdata_idle got %h exp 0", m_prdata); end
  endtask

  task automatic test_write_strobes();
    logic [127:0] rd; logic er; int n;
    rsp_clear();
    apb_xfer(1, 1'b1, 20'h00200, 128'hAABBCCDD_11223344, 16'h00F0, rd, er, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", n); end
    checks++; if (bidx !== 1) begin errors++; $display("FAIL wr_beats got %0d exp 1", bidx); end
    checks++; if (log_addr[0] !== 20'h00204) begin errors++; $display("FAIL wr_addr got %h exp 00204", log_addr[0]); end
    checks++; if (log_data[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL wr_data got %h exp AABBCCDD", log_data[0]); end
    checks++; if (log_strb[0] !== 4'hF) begin errors++; $display("FAIL wr_strb got %h exp F", log_strb[0]); end
    checks++; if (log_wr[0] !== 1'b1) begin errors++; $display("FAIL wr_pwrite got %b exp 1", log_wr[0]); end
    rsp_clear();
    apb_xfer(1, 1'b1, 20'h00200, 128'h12345678_9ABCDEF0, 16'h0000, rd, er, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL wr0_latency got %0d exp 1", n); end
    checks++; if (bidx !== 0) begin errors++; $display("FAIL wr0_beats got %0d exp 0", bidx); end
  endtask

  task automatic test_read128_wait_err();
    logic [127:0] rd; logic er; int n;
    rsp_clear();
    for (int i = 0; i < 4; i++) rsp_data[i] = 32'hC0DE0000 + i;
    rsp_wait[2] = 3;
    rsp_err[3]  = 1'b1;
    apb_xfer(2, 1'b0, 20'h00000, '0, '0, rd, er, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL rd128_latency got %0d exp 12", n); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rd128_slverr got %b exp 1", er); end
    checks++; if (rd !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin errors++; $display("FAIL rd128_data got %h", rd); end
    checks++; if (log_addr[3] !== 20'h0000C) begin errors++; $display("FAIL rd128_addr3 got %h exp 0000C", log_addr[3]); end
    checks++; if (log_addr[2] !== 20'h00008) begin errors++; $display("FAIL rd128_addr2 got %h exp 00008", log_addr[2]); end
  endtask

  task automatic test_posted();
    logic [127:0] rd; logic er; int n;
    rsp_clear();
    rsp_err[1]  = 1'b1;
    rsp_data[2] = 32'h33333333; rsp_data[3] = 32'h44444444;
    apb_xfer(0, 1'b1, 20'h00400, 128'h55556666_77778888, 16'h00FF, rd, er, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL post_wr_latency got %0d exp 1", n); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL post_wr_slverr got %b exp 0", er); end
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL post_busy_drain got %b exp 1", m_busy); end
    apb_xfer(0, 1'b0, 20'h00408, '0, '0, rd, er, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL post_rd_latency got %0d exp 6", n); end
    checks++; if (rd !== 128'h44444444_33333333) begin errors++; $display("FAIL post_rd_data got %h", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL post_rd_slverr got %b exp 0", er); end
    checks++; if (log_addr[1] !== 20'h00404 || log_data[1] !== 32'h55556666) begin errors++; $display("FAIL post_wr_beat1 got %h/%h exp 00404/55556666", log_addr[1], log_data[1]); end
    checks++; if (log_addr[2] !== 20'h00408) begin errors++; $display("FAIL post_rd_addr got %h exp 00408", log_addr[2]); end
    checks++; if (m_perr !== 1'b1) begin errors++; $display("FAIL post_err_set got %b exp 1", m_perr); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL post_busy_end got %b exp 0", m_busy); end
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL post_err_clr got %b exp 0", m_perr); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] rd; logic er; int n;
    rsp_clear();
    rsp_wait[1] = 5;
    which = 0;
    @(posedge clk);
    #1 psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 20'h00300;
    @(posedge clk);
    #1 penable = 1'b1;
    n = 0;
    while (!(m_psel && m_penable && m_paddr == 20'h00304) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 40) begin errors++; $display("FAIL rstmid_reach got %0d cycles exp <40", n); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (m_psel !== 1'b0 || m_penable !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %b%b exp 00", m_psel, m_penable); end
    checks++; if (m_paddr !== 20'h0) begin errors++; $display("FAIL rstmid_paddr got %h exp 0", m_paddr); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", m_busy); end
    checks++; if (m_pready !== 1'b0) begin errors++; $display("FAIL rstmid_pready got %b exp 0", m_pready); end
    psel[0] = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    rsp_clear();
    rsp_data[0] = 32'hCAFE0001; rsp_data[1] = 32'hCAFE0002;
    apb_xfer(0, 1'b0, 20'h00500, '0, '0, rd, er, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rstmid_after_latency got %0d exp 5", n); end
    checks++; if (rd !== 128'hCAFE0002_CAFE0001) begin errors++; $display("FAIL rstmid_after_data got %h", rd); end
  endtask

  task automatic test_addr_mask();
    logic [127:0] rd; logic er; int n;
    rsp_clear();
    rsp_data[0] = 32'h0BADF00D; rsp_data[1] = 32'hFEEDBEEF;
    apb_xfer(1, 1'b0, 20'h0010C, '0, '0, rd, er, n);
    checks++; if (log_addr[0] !== 20'h00108) begin errors++; $display("FAIL mask_addr0 got %h exp 00108", log_addr[0]); end
    checks++; if (log_addr[1] !== 20'h0010C) begin errors++; $display("FAIL mask_addr1 got %h exp 0010C", log_addr[1]); end
    checks++; if (rd !== 128'hFEEDBEEF_0BADF00D) begin errors++; $display("FAIL mask_data got %h", rd); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; err_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rsp_data[i] = '0; rsp_wait[i] = 0; rsp_err[i] = 1'b0;
    end
    test_reset();
    test_read64();
    test_write_strobes();
    test_read128_wait_err();
    test_posted();
    test_reset_mid();
    test_addr_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
